// File: rtl/spi_xfer_sequencer.sv
// spi_xfer_sequencer
//   Byte-stream front end for a register-mapped SPI master core. Each accepted
//   request byte is written to the core's txdata register, the received byte
//   is read back from rxdata and returned on the response channel. Slave
//   select is opened on the first byte of a burst and closed after the byte
//   flagged req_last. If dataavailable does not appear within TIMEOUT cycles,
//   the core status is cleared, select is dropped and an error response
//   (rsp_err=1, rsp_data=0) is returned.
//
// Ports
//   clk, reset_n              clock, async active-low reset
//   req_valid/ready/data/last byte request channel
//   rsp_valid/ready/data/err  received byte channel
//   spi_select/addr/read_n/write_n/wdata/rdata
//                             SPI core register port. Each access strobes for
//                             2 cycles and is followed by at least 1 idle cycle.
//   spi_trdy, spi_rrdy        core readyfordata / dataavailable
module spi_xfer_sequencer #(
  parameter logic [15:0] SS_MASK = 16'h0001,
  parameter int          TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  req_data,
  input  logic        req_last,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [7:0]  rsp_data,
  output logic        rsp_err,
  output logic        spi_select,
  output logic [2:0]  spi_addr,
  output logic        spi_read_n,
  output logic        spi_write_n,
  output logic [15:0] spi_wdata,
  input  logic [15:0] spi_rdata,
  input  logic        spi_trdy,
  input  logic        spi_rrdy
);

  localparam int CW = $clog2(TIMEOUT) + 1;

  typedef enum logic [3:0] {
    IDLE, SS_SET, SS_ON, TX_WAIT, TX_WR, RX_WAIT, RX_RD, RSP, SS_OFF, ABORT
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      phase_q, phase_d;     // 0,1: strobe cycles; 2: explicit idle
  logic            abort_step_q, abort_step_d;
  logic            burst_open_q, burst_open_d;
  logic [7:0]      byte_q, byte_d;
  logic            last_q, last_d;
  logic [7:0]      rsp_data_q, rsp_data_d;
  logic            rsp_err_q, rsp_err_d;
  logic [CW-1:0]   tmo_cnt_q, tmo_cnt_d;

  logic            acc_en, acc_rd;
  logic [2:0]      acc_addr;
  logic [15:0]     acc_wdata;
  logic            rdata_unused;

  assign rdata_unused = ^spi_rdata[15:8];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      phase_q      <= 2'd0;
      abort_step_q <= 1'b0;
      burst_open_q <= 1'b0;
      byte_q       <= 8'h00;
      last_q       <= 1'b0;
      rsp_data_q   <= 8'h00;
      rsp_err_q    <= 1'b0;
      tmo_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      abort_step_q <= abort_step_d;
      burst_open_q <= burst_open_d;
      byte_q       <= byte_d;
      last_q       <= last_d;
      rsp_data_q   <= rsp_data_d;
      rsp_err_q    <= rsp_err_d;
      tmo_cnt_q    <= tmo_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    abort_step_d = abort_step_q;
    burst_open_d = burst_open_q;
    byte_d       = byte_q;
    last_d       = last_q;
    rsp_data_d   = rsp_data_q;
    rsp_err_d    = rsp_err_q;
    tmo_cnt_d    = tmo_cnt_q;
    acc_en       = 1'b0;
    acc_rd       = 1'b0;
    acc_addr     = 3'd0;
    acc_wdata    = 16'h0000;

    // Accesses followed by a non-strobing state end after phase 1; that
    // state supplies the idle cycle. SS_SET and the first ABORT write are
    // followed directly by another access, so they spend phase 2 idle.
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          byte_d  = req_data;
          last_d  = req_last;
          phase_d = 2'd0;
          state_d = burst_open_q ? TX_WAIT : SS_SET;
        end
      end
      SS_SET: begin
        acc_en    = 1'b1;
        acc_addr  = 3'd5;
        acc_wdata = SS_MASK;
        phase_d   = phase_q + 2'd1;
        if (phase_q == 2'd2) begin
          phase_d = 2'd0;
          state_d = SS_ON;
        end
      end
      SS_ON: begin
        acc_en    = 1'b1;
        acc_addr  = 3'd3;
        acc_wdata = 16'h0400;
        phase_d   = phase_q + 2'd1;
        if (phase_q == 2'd1) begin
          phase_d      = 2'd0;
          burst_open_d = 1'b1;
          state_d      = TX_WAIT;
        end
      end
      TX_WAIT: if (spi_trdy) state_d = TX_WR;
      TX_WR: begin
        acc_en    = 1'b1;
        acc_addr  = 3'd1;
        acc_wdata = {8'h00, byte_q};
        phase_d   = phase_q + 2'd1;
        if (phase_q == 2'd1) begin
          phase_d   = 2'd0;
          tmo_cnt_d = '0;
          state_d   = RX_WAIT;
        end
      end
      RX_WAIT: begin
        // dataavailable takes priority over an expiring timeout
        if (spi_rrdy)                              state_d = RX_RD;
        else if (tmo_cnt_q == CW'(TIMEOUT - 1))    state_d = ABORT;
        else                                       tmo_cnt_d = tmo_cnt_q + CW'(1);
      end
      RX_RD: begin
        acc_en   = 1'b1;
        acc_rd   = 1'b1;
        acc_addr = 3'd0;
        phase_d  = phase_q + 2'd1;
        if (phase_q == 2'd1) begin
          phase_d    = 2'd0;
          rsp_data_d = spi_rdata[7:0];
          rsp_err_d  = 1'b0;
          state_d    = RSP;
        end
      end
      RSP: begin
        if (rsp_ready) state_d = (last_q && !rsp_err_q) ? SS_OFF : IDLE;
      end
      SS_OFF: begin
        acc_en    = 1'b1;
        acc_addr  = 3'd3;
        acc_wdata = 16'h0000;
        phase_d   = phase_q + 2'd1;
        if (phase_q == 2'd1) begin
          phase_d      = 2'd0;
          burst_open_d = 1'b0;
          state_d      = IDLE;
        end
      end
      ABORT: begin
        acc_en  = 1'b1;
        phase_d = phase_q + 2'd1;
        if (!abort_step_q) begin
          acc_addr = 3'd2;               // status write clears the core's flags
          if (phase_q == 2'd2) begin
            phase_d      = 2'd0;
            abort_step_d = 1'b1;
          end
        end else begin
          acc_addr = 3'd3;
          if (phase_q == 2'd1) begin
            phase_d      = 2'd0;
            abort_step_d = 1'b0;
            burst_open_d = 1'b0;
            rsp_data_d   = 8'h00;
            rsp_err_d    = 1'b1;
            state_d      = RSP;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    spi_select  = 1'b0;
    spi_addr    = 3'd0;
    spi_read_n  = 1'b1;
    spi_write_n = 1'b1;
    spi_wdata   = 16'h0000;
    if (acc_en && phase_q != 2'd2) begin
      spi_select  = 1'b1;
      spi_addr    = acc_addr;
      spi_wdata   = acc_wdata;
      spi_read_n  = !acc_rd;
      spi_write_n = acc_rd;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RSP);
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_spi_xfer_sequencer.sv
// tb_spi_xfer_sequencer
//   Directed bench with a behavioural SPI core (loopback MISO, programmable
//   shift time). Expected register accesses and responses are queued by the
//   stimulus; independent monitors pop and compare them as the DUT produces
//   them, and also check the access strobe protocol and response stability.
module tb_spi_xfer_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [7:0]  req_data = 8'h00;
  logic        req_last = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [7:0]  rsp_data;
  logic        rsp_err;
  logic        spi_select;
  logic [2:0]  spi_addr;
  logic        spi_read_n;
  logic        spi_write_n;
  logic [15:0] spi_wdata;
  logic [15:0] spi_rdata;
  logic        spi_trdy;
  logic        spi_rrdy;

  spi_xfer_sequencer #(.SS_MASK(16'h0001), .TIMEOUT(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data), .req_last(req_last),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .spi_select(spi_select), .spi_addr(spi_addr), .spi_read_n(spi_read_n),
    .spi_write_n(spi_write_n), .spi_wdata(spi_wdata), .spi_rdata(spi_rdata),
    .spi_trdy(spi_trdy), .spi_rrdy(spi_rrdy)
  );

  always #10 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural SPI core ----------------
  logic [15:0] ss_reg, ctrl_reg;
  logic [7:0]  tx_b, rx_b;
  logic        busy, trdy_m, rrdy_m;
  int          sh_cnt, run_m;
  int          shift_len = 8;
  logic        no_rrdy = 1'b0;
  logic        ss_n, ss_n_prev = 1'b1;
  int          ss_rise = 0;

  assign ss_n      = !(ctrl_reg[10] && ss_reg[0]);
  assign spi_trdy  = trdy_m;
  assign spi_rrdy  = rrdy_m && !no_rrdy;
  assign spi_rdata = {~rx_b, rx_b};

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ss_reg <= 16'h0; ctrl_reg <= 16'h0; tx_b <= 8'h0; rx_b <= 8'h0;
      busy <= 1'b0; trdy_m <= 1'b1; rrdy_m <= 1'b0; sh_cnt <= 0; run_m <= 0;
    end else begin
      if (busy) begin
        if (sh_cnt == 1) begin
          busy <= 1'b0; trdy_m <= 1'b1; rrdy_m <= 1'b1; rx_b <= tx_b;
        end else sh_cnt <= sh_cnt - 1;
      end
      if (spi_select) begin
        run_m <= run_m + 1;
        if (run_m == 1) begin
          if (!spi_write_n) begin
            case (spi_addr)
              3'd5: ss_reg <= spi_wdata;
              3'd3: ctrl_reg <= spi_wdata;
              3'd1: begin
                chk("ss_low_at_tx", {31'd0, ss_n}, 32'd0);
                tx_b <= spi_wdata[7:0]; busy <= 1'b1; trdy_m <= 1'b0; sh_cnt <= shift_len;
              end
              3'd2: rrdy_m <= 1'b0;
              default: ;
            endcase
          end else if (spi_addr == 3'd0) rrdy_m <= 1'b0;
        end
      end else run_m <= 0;
    end
  end

  always @(posedge clk) begin
    ss_n_prev <= ss_n;
    if (ss_n && !ss_n_prev) ss_rise <= ss_rise + 1;
  end

  // ---------------- scoreboard queues ----------------
  typedef struct packed {
    logic [2:0]  addr;
    logic        wr;
    logic [15:0] wdata;
    logic        care;
  } acc_t;

  acc_t       exp_acc[$];
  logic [8:0] exp_rsp[$];   // {err, data}

  task automatic ea(input logic [2:0] a, input logic wr, input logic [15:0] d, input logic care);
    acc_t e;
    e.addr = a; e.wr = wr; e.wdata = d; e.care = care;
    exp_acc.push_back(e);
  endtask

  // ---------------- access monitor ----------------
  int          run = 0, gap = 100, abort_gap = -1;
  logic [2:0]  c_addr;
  logic        c_wr;
  logic [15:0] c_wdata;

  always @(negedge clk) begin
    if (!reset_n) run = 0;
    else if (spi_select) begin
      chk("strobe_onehot", {31'd0, spi_read_n ^ spi_write_n}, 32'd1);
      if (run == 0) begin
        c_addr = spi_addr; c_wr = !spi_write_n; c_wdata = spi_wdata;
        if (spi_addr == 3'd2) abort_gap = gap;
      end else
        chk("strobe_stable", {12'd0, spi_addr, !spi_write_n, spi_wdata}, {12'd0, c_addr, c_wr, c_wdata});
      run++;
    end else begin
      chk("idle_strobes", {30'd0, spi_read_n, spi_write_n}, 32'd3);
      if (run > 0) begin
        acc_t e;
        chk("strobe_len", run, 2);
        if (exp_acc.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_access: got addr %0d wr %0d data %0h expected none", c_addr, c_wr, c_wdata);
        end else begin
          e = exp_acc.pop_front();
          chk("access", {12'd0, c_addr, c_wr, e.care ? c_wdata : 16'h0},
                        {12'd0, e.addr, e.wr, e.care ? e.wdata : 16'h0});
        end
        run = 0; gap = 0;
      end
      gap++;
    end
  end

  // ---------------- response monitor ----------------
  logic       stalled = 1'b0;
  logic [8:0] held;

  always @(negedge clk) begin
    if (!reset_n) stalled = 1'b0;
    else begin
      if (stalled) chk("rsp_hold", {22'd0, rsp_valid, rsp_err, rsp_data}, {22'd0, 1'b1, held});
      if (rsp_valid && rsp_ready) begin
        if (exp_rsp.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_rsp: got %0h expected none", {rsp_err, rsp_data});
        end else chk("rsp", {23'd0, rsp_err, rsp_data}, {23'd0, exp_rsp.pop_front()});
      end
      stalled = rsp_valid && !rsp_ready;
      held    = {rsp_err, rsp_data};
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [7:0] d, input logic l);
    bit ok = 0;
    req_valid = 1'b1; req_data = d; req_last = l;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clk);
      if (req_ready) ok = 1;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (!ok) begin tests++; fails++; $display("FAIL req_accept_timeout: got none expected accept"); end
  endtask

  task automatic wait_done();
    bit ok = 0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk);
      if (exp_acc.size() == 0 && exp_rsp.size() == 0) ok = 1;
    end
    if (!ok) begin
      tests++; fails++;
      $display("FAIL done_timeout: got %0d accesses %0d rsps pending expected 0", exp_acc.size(), exp_rsp.size());
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic single(input logic [7:0] d);
    ea(3'd5, 1, 16'h0001, 1); ea(3'd3, 1, 16'h0400, 1);
    ea(3'd1, 1, {8'h00, d}, 1); ea(3'd0, 0, 16'h0, 0); ea(3'd3, 1, 16'h0000, 1);
    exp_rsp.push_back({1'b0, d});
    send(d, 1'b1);
    wait_done();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int base;
    bit ok;
    repeat (2) @(negedge clk);
    chk("rst_outputs", {8'd0, rsp_valid, rsp_err, rsp_data, spi_select, spi_addr, spi_read_n, spi_write_n, spi_wdata[7:0]},
                       {8'd0, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 1'b1, 1'b1, 8'h00});
    @(posedge clk); #1 reset_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", {16'd0, req_ready, spi_wdata[14:0]}, {16'd0, 1'b1, 15'd0});
    @(posedge clk); #1;

    // single byte with loopback
    single(8'hA5);

    // three-byte burst: select opened once, closed once
    base = ss_rise;
    ea(3'd5, 1, 16'h0001, 1); ea(3'd3, 1, 16'h0400, 1);
    ea(3'd1, 1, 16'h0001, 1); ea(3'd0, 0, 16'h0, 0);
    ea(3'd1, 1, 16'h0002, 1); ea(3'd0, 0, 16'h0, 0);
    ea(3'd1, 1, 16'h0003, 1); ea(3'd0, 0, 16'h0, 0);
    ea(3'd3, 1, 16'h0000, 1);
    exp_rsp.push_back(9'h001); exp_rsp.push_back(9'h002); exp_rsp.push_back(9'h003);
    send(8'h01, 1'b0); send(8'h02, 1'b0); send(8'h03, 1'b1);
    wait_done();
    chk("ss_rise_burst", ss_rise - base, 1);

    // response stall: 20 cycles with a second request waiting
    rsp_ready = 1'b0;
    ea(3'd5, 1, 16'h0001, 1); ea(3'd3, 1, 16'h0400, 1);
    ea(3'd1, 1, 16'h003C, 1); ea(3'd0, 0, 16'h0, 0);
    ea(3'd1, 1, 16'h005A, 1); ea(3'd0, 0, 16'h0, 0);
    ea(3'd3, 1, 16'h0000, 1);
    exp_rsp.push_back(9'h03C); exp_rsp.push_back(9'h05A);
    send(8'h3C, 1'b0);
    ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin @(negedge clk); if (rsp_valid) ok = 1; end
    chk("stall_rsp_seen", {31'd0, ok}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b1; req_data = 8'h5A; req_last = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("stall_state", {22'd0, rsp_valid, req_ready, rsp_data}, {22'd0, 1'b1, 1'b0, 8'h3C});
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    send(8'h5A, 1'b1);
    wait_done();

    // dataavailable arriving on the last timeout cycle still completes
    shift_len = 15;
    single(8'h77);
    shift_len = 8;

    // timeout abort
    no_rrdy = 1'b1;
    abort_gap = -1;
    ea(3'd5, 1, 16'h0001, 1); ea(3'd3, 1, 16'h0400, 1);
    ea(3'd1, 1, 16'h00C3, 1); ea(3'd2, 1, 16'h0, 0); ea(3'd3, 1, 16'h0000, 1);
    exp_rsp.push_back(9'h100);
    send(8'hC3, 1'b1);
    wait_done();
    chk("abort_wait_cycles", abort_gap, 16);
    no_rrdy = 1'b0;

    // burst closed by abort: next byte reopens select
    single(8'h11);

    // reset during first strobe cycle of the txdata write
    ea(3'd5, 1, 16'h0001, 1); ea(3'd3, 1, 16'h0400, 1);
    send(8'h99, 1'b1);
    ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (spi_select && spi_addr == 3'd1 && !spi_write_n) ok = 1;
    end
    chk("txwr_seen", {31'd0, ok}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_outputs", {9'd0, spi_select, spi_addr, spi_read_n, spi_write_n, spi_wdata, rsp_valid, rsp_err},
                          {9'd0, 1'b0, 3'd0, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0});
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    chk("midrst_acc_left", exp_acc.size(), 0);
    single(8'h42);

    chk("rsp_queue_empty", exp_rsp.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule
